// File: rtl/pe_uno_ctrl_if.sv
// Bundle of every handshake, ROM and PE-side signal of the unary-op PE sharing controller.
// Latency: none, wires only.
// Backpressure: carries gemm_req/gemm_grant arbitration, req_valid/req_ready and rsp_valid/rsp_ready.
interface pe_uno_ctrl_if #(
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int N_TERM = 8
);
    localparam int AW = 2 + $clog2(N_TERM);

    logic              gemm_req;
    logic              gemm_grant;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [MUL_BW-1:0] req_x;
    logic [AW-1:0]     coef_addr;
    logic [MUL_BW-1:0] coef_data;
    logic [1:0]        pe_mode;
    logic [MUL_BW-1:0] pe_var;
    logic [MUL_BW-1:0] pe_wc;
    logic [ACC_BW-1:0] pe_mac;
    logic [ACC_BW-1:0] pe_o;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ACC_BW-1:0] rsp_data;
    logic              rsp_err;

    // Controller side.
    modport master (
        input  gemm_req,
        output gemm_grant,
        input  req_valid,
        output req_ready,
        input  req_op,
        input  req_x,
        output coef_addr,
        input  coef_data,
        output pe_mode,
        output pe_var,
        output pe_wc,
        output pe_mac,
        input  pe_o,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data,
        output rsp_err
    );

    // Environment side: GEMM stream, requester, ROM, PE and result consumer.
    modport slave (
        output gemm_req,
        input  gemm_grant,
        output req_valid,
        input  req_ready,
        output req_op,
        output req_x,
        input  coef_addr,
        output coef_data,
        input  pe_mode,
        input  pe_var,
        input  pe_wc,
        input  pe_mac,
        output pe_o,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data,
        input  rsp_err
    );
endinterface

// File: rtl/pe_uno_ctrl.sv
// Time-shares one PE between the GEMM stream and unary div/exp/log ops evaluated by Horner recurrence.
// Latency: accept -> rsp_valid is N_TERM+4 cycles; illegal op responds the cycle after accept.
// Backpressure: GEMM wins except when a unary request has starved STARVE_MAX cycles; rsp held until rsp_ready.
module pe_uno_ctrl #(
    parameter int MUL_BW     = 16,
    parameter int ACC_BW     = 32,
    parameter int N_TERM     = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_uno_ctrl_if.master bus
);
    localparam int TW = $clog2(N_TERM);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int AW = 2 + TW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t            state;
    logic [1:0]        op_r;
    logic [TW-1:0]     term_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              wc_sel;
    logic              mac_fb;
    logic [1:0]        pe_mode_r;
    logic [MUL_BW-1:0] pe_var_r;
    logic [AW-1:0]     coef_addr_r;
    logic              rsp_valid_r;
    logic [ACC_BW-1:0] rsp_data_r;
    logic              rsp_err_r;

    logic in_idle;
    logic uno_win;
    logic accept;

    // Arbitration is decided combinationally so GEMM gets the PE in the same cycle it asks.
    always_comb begin
        in_idle = (state == S_IDLE);
        uno_win = ~bus.gemm_req | (starve_cnt == SW'(STARVE_MAX));
        accept  = in_idle & uno_win & bus.req_valid;
    end

    assign bus.gemm_grant = in_idle & bus.gemm_req & ~uno_win;
    assign bus.req_ready  = in_idle & uno_win;

    // Coefficient and accumulator paths are direct feedthroughs gated by registered selects:
    // the ROM word arrives a cycle after its address and the PE result is fed back the same cycle.
    assign bus.pe_wc  = wc_sel ? bus.coef_data : '0;
    assign bus.pe_mac = mac_fb ? bus.pe_o : '0;

    assign bus.pe_mode   = pe_mode_r;
    assign bus.pe_var    = pe_var_r;
    assign bus.coef_addr = coef_addr_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;

    // Sequencer: IDLE -> LOAD -> ISSUE (N_TERM) -> DRAIN (2) -> RESP; illegal op goes straight to RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_r        <= '0;
            term_cnt    <= '0;
            starve_cnt  <= '0;
            wc_sel      <= 1'b0;
            mac_fb      <= 1'b0;
            pe_mode_r   <= '0;
            pe_var_r    <= '0;
            coef_addr_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        starve_cnt <= '0;
                        op_r       <= bus.req_op;
                        if (bus.req_op == 2'b00) begin
                            // Illegal op never touches the PE.
                            state       <= S_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_data_r  <= '0;
                        end else begin
                            state       <= S_LOAD;
                            pe_mode_r   <= bus.req_op;
                            pe_var_r    <= bus.req_x;
                            coef_addr_r <= {bus.req_op, TW'(N_TERM - 1)};
                        end
                    end else if (bus.req_valid && bus.gemm_req && !uno_win) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end

                S_LOAD: begin
                    state       <= S_ISSUE;
                    term_cnt    <= '0;
                    wc_sel      <= 1'b1;
                    coef_addr_r <= {op_r, TW'(N_TERM - 2)};
                end

                S_ISSUE: begin
                    // The first two terms start from a zero accumulator; feedback begins at term 2.
                    mac_fb <= (term_cnt != '0);
                    if (term_cnt == TW'(N_TERM - 1)) begin
                        state       <= S_DRAIN;
                        term_cnt    <= '0;
                        wc_sel      <= 1'b0;
                        coef_addr_r <= '0;
                    end else begin
                        term_cnt <= term_cnt + 1'b1;
                        if (32'(term_cnt) < N_TERM - 2) begin
                            coef_addr_r <= coef_addr_r - 1'b1;
                        end else begin
                            coef_addr_r <= '0;
                        end
                    end
                end

                S_DRAIN: begin
                    // Two cycles let the PE pipeline flush the last term into o_o.
                    if (term_cnt == TW'(1)) begin
                        state       <= S_RESP;
                        term_cnt    <= '0;
                        mac_fb      <= 1'b0;
                        pe_mode_r   <= '0;
                        pe_var_r    <= '0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_data_r  <= bus.pe_o;
                    end else begin
                        term_cnt <= term_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        rsp_data_r  <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_uno_ctrl.sv
// Directed bench for pe_uno_ctrl with a sync ROM (coef k = k) and a toy registered PE model.
// Latency: checks timing cycle-by-cycle relative to the accept cycle A.
// Backpressure: exercises GEMM starvation guard and rsp_ready stalls.
module tb_pe_uno_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    pe_uno_ctrl_if #(.MUL_BW(16), .ACC_BW(32), .N_TERM(8)) bus ();

    pe_uno_ctrl #(
        .MUL_BW(16),
        .ACC_BW(32),
        .N_TERM(8),
        .STARVE_MAX(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync ROM: coefficient value equals its term index.
    always @(posedge clk) bus.coef_data <= {13'd0, bus.coef_addr[2:0]};

    // Toy PE: o_o <= mac + wc + var one cycle later while active.
    always @(posedge clk)
        bus.pe_o <= (bus.pe_mode != 2'b00) ? (bus.pe_mac + 32'(bus.pe_wc) + 32'(bus.pe_var)) : 32'd0;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed pe_o for op 10, x=0x100 at cycle A+t (t=4..11).
    function automatic logic [31:0] mac1(input int t);
        case (t)
            4:       return 32'd262;
            5:       return 32'd523;
            6:       return 32'd783;
            7:       return 32'd1042;
            8:       return 32'd1300;
            9:       return 32'd1557;
            10:      return 32'd1813;
            11:      return 32'd2069;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.gemm_req  = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_x     = 16'h0000;
        bus.rsp_ready = 1'b0;

        // Reset state
        nxt(); nxt(); nxt();
        smp();
        chk("rst_mode", bus.pe_mode, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_coef_addr", bus.coef_addr, 0);
        chk("rst_pe_mac", bus.pe_mac, 0);
        chk("rst_grant_noreq", bus.gemm_grant, 0);
        nxt();
        bus.gemm_req = 1'b1;
        smp();
        chk("rst_grant_req", bus.gemm_grant, 1);
        nxt();
        rst_n = 1'b1;
        bus.gemm_req = 1'b0;

        // Test 1/2: exp op, full Horner timeline
        nxt();
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_x = 16'h0100; bus.rsp_ready = 1'b1;
        smp();
        chk("t1_req_ready", bus.req_ready, 1);
        chk("t1_grant", bus.gemm_grant, 0);
        nxt();
        bus.req_valid = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            smp();
            chk("t1_mode", bus.pe_mode, (t <= 11) ? 2 : 0);
            chk("t1_var", bus.pe_var, (t <= 11) ? 16'h0100 : 0);
            chk("t1_coef_addr", bus.coef_addr, (t <= 8) ? ((2 << 3) | (8 - t)) : 0);
            chk("t1_wc", bus.pe_wc, (t >= 2 && t <= 9) ? (9 - t) : 0);
            chk("t1_mac", bus.pe_mac, mac1(t));
            chk("t1_rsp_valid", bus.rsp_valid, (t == 12) ? 1 : 0);
            chk("t1_req_ready_busy", bus.req_ready, 0);
            if (t == 12) begin
                chk("t1_rsp_data", bus.rsp_data, 2069);
                chk("t1_rsp_err", bus.rsp_err, 0);
            end
            nxt();
        end
        smp();
        chk("t1_idle_valid", bus.rsp_valid, 0);
        chk("t1_idle_ready", bus.req_ready, 1);

        // Test 3: starvation guard
        nxt();
        bus.gemm_req = 1'b1; bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_x = 16'h0005;
        for (int i = 0; i < 15; i++) begin
            smp();
            chk("t3_grant", bus.gemm_grant, 1);
            chk("t3_ready_blocked", bus.req_ready, 0);
            nxt();
        end
        smp();
        chk("t3_ready_win", bus.req_ready, 1);
        chk("t3_grant_lose", bus.gemm_grant, 0);
        nxt();
        bus.req_valid = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            smp();
            chk("t3_grant_busy", bus.gemm_grant, 0);
            if (t == 12) chk("t3_rsp_valid", bus.rsp_valid, 1);
            nxt();
        end
        smp();
        chk("t3_grant_back", bus.gemm_grant, 1);

        // Test 4: illegal op
        nxt();
        bus.gemm_req = 1'b0; bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_x = 16'h1234;
        smp();
        chk("t4_req_ready", bus.req_ready, 1);
        nxt();
        bus.req_valid = 1'b0;
        smp();
        chk("t4_rsp_valid", bus.rsp_valid, 1);
        chk("t4_rsp_err", bus.rsp_err, 1);
        chk("t4_rsp_data", bus.rsp_data, 0);
        chk("t4_mode", bus.pe_mode, 0);
        chk("t4_ready_resp", bus.req_ready, 0);
        nxt();
        smp();
        chk("t4_idle_valid", bus.rsp_valid, 0);
        chk("t4_idle_err", bus.rsp_err, 0);

        // Test 5: response stall, div op x=3 -> 45
        nxt();
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_x = 16'h0003; bus.rsp_ready = 1'b0;
        smp();
        chk("t5_req_ready", bus.req_ready, 1);
        nxt();
        bus.req_valid = 1'b0;
        smp();
        chk("t5_mode", bus.pe_mode, 1);
        for (int t = 1; t <= 11; t++) nxt();
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("t5_hold_valid", bus.rsp_valid, 1);
            chk("t5_hold_data", bus.rsp_data, 45);
            chk("t5_hold_err", bus.rsp_err, 0);
            chk("t5_hold_ready", bus.req_ready, 0);
            nxt();
        end
        bus.rsp_ready = 1'b1;
        smp();
        chk("t5_rel_valid", bus.rsp_valid, 1);
        chk("t5_rel_data", bus.rsp_data, 45);
        nxt();
        smp();
        chk("t5_idle_valid", bus.rsp_valid, 0);
        chk("t5_idle_ready", bus.req_ready, 1);

        // Test 6: reset mid-op
        nxt();
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_x = 16'h0100;
        smp();
        chk("t6_req_ready", bus.req_ready, 1);
        nxt();
        bus.req_valid = 1'b0;
        for (int t = 1; t <= 4; t++) nxt();
        rst_n = 1'b0;
        smp();
        chk("t6_mode_before", bus.pe_mode, 2);
        nxt();
        rst_n = 1'b1;
        smp();
        chk("t6_mode", bus.pe_mode, 0);
        chk("t6_var", bus.pe_var, 0);
        chk("t6_coef_addr", bus.coef_addr, 0);
        chk("t6_wc", bus.pe_wc, 0);
        chk("t6_mac", bus.pe_mac, 0);
        chk("t6_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rsp_err", bus.rsp_err, 0);
        chk("t6_rsp_data", bus.rsp_data, 0);
        chk("t6_grant", bus.gemm_grant, 0);
        chk("t6_ready", bus.req_ready, 1);
        for (int i = 0; i < 10; i++) begin
            nxt();
            smp();
            chk("t6_no_rsp", bus.rsp_valid, 0);
            chk("t6_idle_mode", bus.pe_mode, 0);
        end
        nxt();
        bus.req_valid = 1'b1; bus.req_op = 2'b11; bus.req_x = 16'h0000;
        smp();
        chk("t6_new_ready", bus.req_ready, 1);
        nxt();
        bus.req_valid = 1'b0;
        smp();
        chk("t6_new_mode", bus.pe_mode, 3);
        chk("t6_new_addr", bus.coef_addr, 5'h1F);
        for (int t = 2; t <= 12; t++) nxt();
        smp();
        chk("t6_new_rsp_valid", bus.rsp_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
